// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI data-path FIFOs.
package spi_pkg;

  localparam int unsigned SPI_DATA_W     = 16;
  localparam int unsigned SPI_FIFO_DEPTH = 8;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module spi_fifo_ram
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W,
  parameter int unsigned DEPTH  = SPI_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Show-ahead read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_fifo_ctrl.sv
// Parametrised synchronous FIFO for the SPI RX/TX paths: pointers, flags, sticky errors.
module spi_fifo_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W,
  parameter int unsigned DEPTH  = SPI_FIFO_DEPTH,
  parameter int unsigned AF_LVL = 6,
  parameter int unsigned AE_LVL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wen,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     ren,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_n;
  logic [PW-1:0] rptr_n;
  logic [PW-1:0] count_n;
  logic          do_wr;
  logic          do_rd;
  logic          ovf_set;
  logic          udf_set;

  // Accept decisions use only registered flags; flush masks all requests.
  always_comb begin
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    wptr_n  = wptr;
    rptr_n  = rptr;
    if (flush) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      do_wr   = wen && (!full || ren);
      do_rd   = ren && !empty;
      ovf_set = wen && !do_wr;
      udf_set = ren && !do_rd;
      wptr_n  = wptr + PW'(do_wr);
      rptr_n  = rptr + PW'(do_rd);
    end
    count_n = wptr_n - rptr_n;
  end

  // Pointer, level flag and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      count        <= count_n;
      full         <= (wptr_n[AW-1:0] == rptr_n[AW-1:0]) && (wptr_n[AW] != rptr_n[AW]);
      empty        <= (wptr_n == rptr_n);
      almost_full  <= (count_n >= PW'(AF_LVL));
      almost_empty <= (count_n <= PW'(AE_LVL));
      overflow     <= (overflow  && !clr_err) || ovf_set;
      underflow    <= (underflow && !clr_err) || udf_set;
    end
  end

  spi_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Scoreboard bench for spi_fifo_ctrl (DATA_W=16, DEPTH=8, AF_LVL=6, AE_LVL=1).
module tb_spi_fifo_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wen = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          ren = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rdata;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  logic [DW-1:0] sb[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  spi_fifo_ctrl #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wen          (wen),
    .wdata        (wdata),
    .ren          (ren),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every status output (and head data when non-empty) against the model.
  task automatic check_state();
    int sz;
    sz = sb.size();
    check("count",        32'(count),        32'(sz));
    check("full",         32'(full),         32'(sz == DEPTH));
    check("empty",        32'(empty),        32'(sz == 0));
    check("almost_full",  32'(almost_full),  32'(sz >= AF));
    check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
    if (sz > 0) check("head", 32'(rdata), 32'(sb[0]));
  endtask

  // One clock of stimulus; expected data popped and compared on accepted reads.
  task automatic step(input logic r_rst, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic f, input logic c);
    int   sz;
    logic wa;
    logic ra;
    logic [DW-1:0] exp_d;
    rst = r_rst; wen = w; wdata = d; ren = r; flush = f; clr_err = c;
    @(negedge clk);
    sz = sb.size();
    wa = w && ((sz < DEPTH) || (r && sz == DEPTH));
    ra = r && (sz > 0);
    if (r_rst) begin
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (f) begin
      sb.delete();
      m_ovf = m_ovf && !c;
      m_udf = m_udf && !c;
    end else begin
      if (ra) begin
        exp_d = sb.pop_front();
        check("rdata", 32'(rdata), 32'(exp_d));
      end
      if (wa) sb.push_back(d);
      m_ovf = (m_ovf && !c) || (w && !wa);
      m_udf = (m_udf && !c) || (r && !ra);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_state();
  endtask

  task automatic wr(input logic [DW-1:0] d); step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic rd();                       step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0); endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill and drain
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    for (int i = 0; i < 8; i++) rd();

    // Overflow, then clear, then drain original data
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    wr(16'hDEAD);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) rd();

    // Read and write while full
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    step(1'b0, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) rd();

    // Underflow with simultaneous write on empty
    step(1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    rd();
    rd();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Wrap-around at constant count 3
    for (int i = 0; i < 3; i++) wr(DW'(16'h0100 + i));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, DW'(16'h0200 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd();

    // Flush with concurrent write
    for (int i = 0; i < 5; i++) wr(DW'(16'h0300 + i));
    step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    wr(16'h0401);
    rd();

    // Reset mid-operation with count 4 and overflow set
    for (int i = 0; i < 8; i++) wr(DW'(16'h0500 + i));
    wr(16'hDEAD);
    for (int i = 0; i < 4; i++) rd();
    step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
